fifo_write_arbiter: RTL and testbench
=====================================

# fifo_write_arbiter

Round-robin arbiter that shares the write port of one interconnect FIFO among `NUM_REQ` requesters, each with a valid/ready handshake. It sits between the requester-side bus masters and the FIFO's `data_in`/`write_enable`/`full` pins. It decides which requester writes each cycle and keeps a rotating priority pointer so every requester gets fair access. Optionally it holds the grant for a multi-beat packet so that beats from different requesters never interleave inside the FIFO.

## Interface
- `NUM_REQ`, 4: number of requesters; legal range 1..16, need not be a power of two.
- `DATA_WIDTH`, 32: width of one FIFO entry.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `req_valid` input `NUM_REQ`: bit i means requester i presents a beat.
- `req_data` input `NUM_REQ*DATA_WIDTH`: requester i's beat occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_last` input `NUM_REQ`: bit i marks requester i's current beat as the final beat of its packet. Ignored unless `FIFO_ARB_LOCK_EN` is defined.
- `req_ready` output `NUM_REQ`: one-hot or zero; bit i means requester i's beat is accepted this cycle.
- `fifo_data_in` output `DATA_WIDTH`: data driven to the FIFO's `data_in`.
- `fifo_write_enable` output 1: drives the FIFO's `write_enable`.
- `fifo_full` input 1: the FIFO's `full` flag.
- `grant_id` output `max(1,$clog2(NUM_REQ))`: index of the current or most recent winner.
- `locked` output 1: high while a packet lock is held. Tied to 0 when `FIFO_ARB_LOCK_EN` is undefined.

## Operation
- **Eligible set.** In IDLE, the eligible requesters are all i with `req_valid[i]`. In LOCKED, only `lock_id` is eligible.
- **Winner selection.** The winner is the first eligible index found scanning `ptr`, `ptr+1`, …, `NUM_REQ-1`, 0, …, `ptr-1`. Index arithmetic wraps modulo `NUM_REQ`, with explicit handling for non-power-of-two values.
- **Transfer.** A transfer occurs when a winner exists, `fifo_full`=0 and `rst`=0. In that cycle `req_ready[winner]`=1, `fifo_write_enable`=1 and `fifo_data_in`=winner's data.
- **Idle outputs.** Whenever no transfer occurs, `req_ready`=0 and `fifo_write_enable`=0. `fifo_data_in` then shows the winner's data, or all zeros if there is no winner.
- **Pointer update.** On a transfer, `ptr` <= (winner+1) mod `NUM_REQ`. With the lock feature enabled, this update happens only on a `last` beat. Without a transfer, `ptr` holds.
- **`grant_id`.** Registered; loads the winner on every transfer and otherwise holds.
- **State machine (`FIFO_ARB_LOCK_EN` only).**
  - IDLE -> LOCKED on a transfer with `req_last[winner]`=0; `lock_id` <= winner.
  - LOCKED -> IDLE on a transfer with `req_last[lock_id]`=1.
  - LOCKED holds while `req_valid[lock_id]`=0; other requesters stay blocked.
  - A single-beat packet (`last`=1 in IDLE) never enters LOCKED.
- **Full.** While `fifo_full`=1, nothing is accepted. Pointer, state and `lock_id` all hold.
- **Reset.** `rst`=1 at any edge forces `ptr`=0, `grant_id`=0, state IDLE and `locked`=0. This includes reset in the middle of a packet, which abandons the lock. During reset, `req_ready`=0 and `fifo_write_enable`=0.
- **`NUM_REQ`=1.** `ptr` stays 0 and the block degenerates to a pass-through gated by `fifo_full`.

## Timing
- Handshake is combinational, with zero cycles from `req_valid`/`fifo_full` to `req_ready`/`fifo_write_enable`. The FIFO's `full` is a register decode, so no combinational loop exists.
- A beat is consumed on the rising edge where valid and ready are both 1. The requester may change data in the following cycle.
- `ptr`, state, `lock_id` and `grant_id` update on that same edge and affect selection from the next cycle.
- Throughput: one beat per cycle while the FIFO is not full. After a requester wins a non-locked beat, back-to-back beats alternate between competing requesters.
- `req_ready` must not depend on the requester's own `req_data`.

## Configuration
- Macro: `FIFO_ARB_LOCK_EN`.
- **Defined:** the IDLE/LOCKED state machine and `lock_id` register are built, `req_last` is honoured, and `locked` is live. A packet's beats are written to the FIFO contiguously.
- **Undefined:** no state machine or `lock_id`; `req_last` is unused and `locked`=0. The pointer advances after every transfer, so arbitration is per beat.

## Structure
- Shared package `interconnect_pkg` holds:
  - state encodings `ARB_IDLE` and `ARB_LOCKED`;
  - function `req_idx_w(n)`, returning `max(1,$clog2(n))`;
  - the default requester count constant.
- One sub-module, `rr_priority_select`: purely combinational. It takes a request vector and pointer and returns `found` and `index`. It is reusable for the read-side scheduler.

## Test plan
- **Reset state.** `rst`=1 for 2 cycles with all `req_valid` high -> `req_ready`=0, `fifo_write_enable`=0, `grant_id`=0, `locked`=0.
- **Round-robin order.** `NUM_REQ`=4, all four valid continuously, FIFO never full, lock off -> grants 0,1,2,3,0,1 on consecutive cycles, each writing its own distinct data.
- **Full backpressure.** Requesters 1 and 2 valid, `fifo_full`=1 for 3 cycles, then 0 -> no ready during the full cycles, then grants 1 then 2 with the pointer unchanged across the stall.
- **Packet lock.** Lock on: requester 2 sends a 3-beat packet (`last` on beat 3) while requester 0 is valid throughout -> beats 2,2,2 are written consecutively, `locked`=1 for 2 cycles, then requester 0 wins.
- **Reset mid-lock.** Lock on: assert `rst` after beat 1 of requester 1's packet -> `locked`=0 and `ptr`=0 on the next cycle; requester 0 wins if valid.
- **Non-power-of-two wrap.** `NUM_REQ`=3 with requesters 2 and 0 valid -> grant sequence 0,2,0,2 with correct wrap from 2 to 0.

Source files
------------

// File: rtl/interconnect_pkg.sv
// interconnect_pkg
//   Shared definitions for the interconnect FIFO arbiters.
//   - arb_state_t : packet-lock state encoding (ARB_IDLE / ARB_LOCKED)
//   - req_idx_w() : index width for n requesters, max(1, $clog2(n))
//   - DEFAULT_NUM_REQ : default requester count
package interconnect_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  localparam int unsigned DEFAULT_NUM_REQ = 4;

  function automatic int unsigned req_idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// rr_priority_select
//   Combinational round-robin scan: finds the first set bit of i_req
//   starting at i_ptr and wrapping modulo NUM_REQ (any NUM_REQ, not only
//   powers of two). Shared by the write arbiter and read-side scheduler.
// Ports:
//   i_req   [NUM_REQ-1:0] request vector
//   i_ptr   [IDX_W-1:0]   scan start index, must be < NUM_REQ
//   o_found               at least one request set
//   o_index [IDX_W-1:0]   index of first request at/after i_ptr
module rr_priority_select #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic               o_found,
  output logic [IDX_W-1:0]   o_index
);

  always_comb begin
    logic             w_hit;
    logic [IDX_W:0]   w_pos;
    w_hit   = 1'b0;
    w_pos   = '0;
    o_index = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      // ptr + k < 2*NUM_REQ, so a single conditional subtract wraps it.
      w_pos = {1'b0, i_ptr} + (IDX_W+1)'(k);
      if (w_pos >= (IDX_W+1)'(NUM_REQ)) begin
        w_pos = w_pos - (IDX_W+1)'(NUM_REQ);
      end
      if (!w_hit && i_req[w_pos[IDX_W-1:0]]) begin
        w_hit   = 1'b1;
        o_index = w_pos[IDX_W-1:0];
      end
    end
    o_found = w_hit;
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
//   Round-robin arbiter sharing one FIFO write port among NUM_REQ
//   valid/ready requesters. Handshake is combinational; pointer, grant_id
//   and lock state are registered. Synchronous active-high reset.
// Optional feature (macro FIFO_ARB_LOCK_EN): hold the grant for a whole
//   packet (until req_last) so packet beats never interleave in the FIFO.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_last  per-requester beat valid / last-beat flag
//   req_data            packed beats, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready           one-hot (or zero) accept
//   fifo_data_in        data to FIFO
//   fifo_write_enable   FIFO write strobe
//   fifo_full           FIFO full flag
//   grant_id            index of current/most recent winner
//   locked              packet lock held (0 without FIFO_ARB_LOCK_EN)
module fifo_write_arbiter
  import interconnect_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DEFAULT_NUM_REQ,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic                          fifo_write_enable,
  input  logic                          fifo_full,
  output logic [req_idx_w(NUM_REQ)-1:0] grant_id,
  output logic                          locked
);

  localparam int unsigned IW = req_idx_w(NUM_REQ);

  logic [IW-1:0]      r_ptr;
  logic [IW-1:0]      r_grant_id;
  logic [NUM_REQ-1:0] w_elig;
  logic               w_found;
  logic [IW-1:0]      w_win;
  logic               w_xfer;
  logic               w_ptr_adv;
  logic [IW-1:0]      w_ptr_next;

  rr_priority_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IW)
  ) u_sel (
    .i_req   (w_elig),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_index (w_win)
  );

  assign w_xfer     = w_found & ~fifo_full & ~rst;
  assign w_ptr_next = (w_win == IW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;

  // Output mux; ready depends only on valid/lock/full, never on data.
  always_comb begin
    req_ready    = '0;
    fifo_data_in = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_found && (w_win == IW'(i))) begin
        fifo_data_in = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        req_ready[i] = w_xfer;
      end
    end
  end

  assign fifo_write_enable = w_xfer;

`ifdef FIFO_ARB_LOCK_EN
  arb_state_t    r_state;
  arb_state_t    w_state_next;
  logic [IW-1:0] r_lock_id;
  logic          w_win_last;

  always_comb begin
    w_elig = req_valid;
    if (r_state == ARB_LOCKED) begin
      w_elig = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (r_lock_id == IW'(i)) w_elig[i] = req_valid[i];
      end
    end
  end

  always_comb begin
    w_win_last = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_win == IW'(i)) w_win_last = req_last[i];
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ptr_adv    = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_xfer) begin
          if (w_win_last) w_ptr_adv    = 1'b1;
          else            w_state_next = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        if (w_xfer && w_win_last) begin
          w_state_next = ARB_IDLE;
          w_ptr_adv    = 1'b1;
        end
      end
      default: w_state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ARB_IDLE;
      r_lock_id <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_xfer && (r_state == ARB_IDLE) && !w_win_last) r_lock_id <= w_win;
    end
  end

  assign locked = (r_state == ARB_LOCKED);
`else
  logic w_unused_last;

  assign w_elig        = req_valid;
  assign w_ptr_adv     = w_xfer;
  assign locked        = 1'b0;
  assign w_unused_last = ^req_last;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= '0;
      r_grant_id <= '0;
    end else if (w_xfer) begin
      r_grant_id <= w_win;
      if (w_ptr_adv) r_ptr <= w_ptr_next;
    end
  end

  assign grant_id = r_grant_id;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
module tb_fifo_write_arbiter;
  localparam int DW = 32;
`ifdef FIFO_ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_full = 1'b0;

  logic [3:0]    valid4 = '0, last4 = '0, ready4;
  logic [4*DW-1:0] data4 = '0;
  logic [DW-1:0] dout4;
  logic          we4, locked4;
  logic [1:0]    grant4;

  logic [2:0]    valid3 = '0, last3 = '0, ready3;
  logic [3*DW-1:0] data3 = '0;
  logic [DW-1:0] dout3;
  logic          we3, locked3;
  logic [1:0]    grant3;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  int m_ptr[2], m_grant[2], m_lockid[2];
  bit m_lock[2];

  always #5 clk = ~clk;

  fifo_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(DW)) u_dut4 (
    .clk(clk), .rst(rst), .req_valid(valid4), .req_data(data4), .req_last(last4),
    .req_ready(ready4), .fifo_data_in(dout4), .fifo_write_enable(we4),
    .fifo_full(fifo_full), .grant_id(grant4), .locked(locked4));

  fifo_write_arbiter #(.NUM_REQ(3), .DATA_WIDTH(DW)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(valid3), .req_data(data3), .req_last(last3),
    .req_ready(ready3), .fifo_data_in(dout3), .fifo_write_enable(we3),
    .fifo_full(fifo_full), .grant_id(grant3), .locked(locked3));

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, got, exp);
    end
  endtask

  // Reference: scan from ptr modulo n for a valid requester (or only the lock
  // holder), then apply the transfer/pointer/lock rules.
  task automatic model_cycle(input int inst, input int n,
                             input logic [15:0] v, input logic [15:0] l,
                             input logic [DW-1:0] d[16],
                             input logic [15:0] a_ready, input logic a_we,
                             input logic [DW-1:0] a_data, input int a_grant,
                             input logic a_locked);
    int win = 0;
    bit found = 1'b0;
    bit xfer;
    if (m_lock[inst]) begin
      if (v[m_lockid[inst]]) begin found = 1'b1; win = m_lockid[inst]; end
    end else begin
      for (int k = 0; k < n; k++) begin
        if (!found && v[(m_ptr[inst] + k) % n]) begin
          found = 1'b1;
          win = (m_ptr[inst] + k) % n;
        end
      end
    end
    xfer = found && !fifo_full && !rst;
    chk($sformatf("u%0d.ready", inst), a_ready, xfer ? (64'd1 << win) : 64'd0);
    chk($sformatf("u%0d.we", inst), a_we, xfer);
    chk($sformatf("u%0d.data", inst), a_data, found ? d[win] : '0);
    chk($sformatf("u%0d.grant", inst), a_grant, m_grant[inst]);
    chk($sformatf("u%0d.locked", inst), a_locked, m_lock[inst]);
    if (rst) begin
      m_ptr[inst] = 0; m_grant[inst] = 0; m_lock[inst] = 1'b0; m_lockid[inst] = 0;
    end else if (xfer) begin
      m_grant[inst] = win;
      if (!LOCK || l[win]) begin
        m_ptr[inst] = (win + 1) % n;
        m_lock[inst] = 1'b0;
      end else if (!m_lock[inst]) begin
        m_lock[inst] = 1'b1;
        m_lockid[inst] = win;
      end
    end
  endtask

  initial begin
    logic [DW-1:0] d4[16];
    logic [DW-1:0] d3[16];
    for (int i = 0; i < 2; i++) begin
      m_ptr[i] = 0; m_grant[i] = 0; m_lock[i] = 1'b0; m_lockid[i] = 0;
    end
    forever begin
      @(negedge clk);
      if (chk_on) begin
        for (int i = 0; i < 16; i++) begin
          d4[i] = (i < 4) ? data4[i*DW +: DW] : '0;
          d3[i] = (i < 3) ? data3[i*DW +: DW] : '0;
        end
        model_cycle(0, 4, {12'b0, valid4}, {12'b0, last4}, d4,
                    {12'b0, ready4}, we4, dout4, int'(grant4), locked4);
        model_cycle(1, 3, {13'b0, valid3}, {13'b0, last3}, d3,
                    {13'b0, ready3}, we3, dout3, int'(grant3), locked3);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int rr_exp[6] = '{0, 1, 2, 3, 0, 1};
  int w3_exp[4] = '{0, 2, 0, 2};

  initial begin
    for (int i = 0; i < 4; i++) data4[i*DW +: DW] = 32'hA000_0000 + i;
    for (int i = 0; i < 3; i++) data3[i*DW +: DW] = 32'hB000_0000 + i;
    rst = 1'b1;
    valid4 = 4'hF;
    valid3 = 3'h7;
    tick();
    chk_on = 1'b1;
    tick();
    @(negedge clk);
    chk("rst.ready", ready4, 4'b0000);
    chk("rst.we", we4, 1'b0);
    chk("rst.grant", grant4, 2'd0);
    chk("rst.locked", locked4, 1'b0);
    tick();

    // Round robin, all four valid
    rst = 1'b0;
    valid3 = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("rr.ready", ready4, 4'b0001 << rr_exp[c]);
      chk("rr.data", dout4, 32'hA000_0000 + rr_exp[c]);
      tick();
    end

    // Full backpressure
    do_reset();
    valid4 = 4'b0110;
    fifo_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("full.ready", ready4, 4'b0000);
      chk("full.we", we4, 1'b0);
      chk("full.data", dout4, 32'hA000_0001);
      tick();
    end
    fifo_full = 1'b0;
    @(negedge clk);
    chk("full.rel1", ready4, 4'b0010);
    tick();
    @(negedge clk);
    chk("full.rel2", ready4, 4'b0100);
    chk("full.grant", grant4, 2'd1);
    tick();

`ifdef FIFO_ARB_LOCK_EN
    // Packet lock: single beat from 1 moves ptr to 2, then 3-beat packet from 2
    do_reset();
    valid4 = 4'b0010;
    last4 = 4'b0010;
    @(negedge clk);
    chk("lk.single", ready4, 4'b0010);
    tick();
    valid4 = 4'b0101;
    for (int b = 0; b < 3; b++) begin
      last4 = (b == 2) ? 4'b0100 : 4'b0000;
      @(negedge clk);
      chk("lk.beat", ready4, 4'b0100);
      chk("lk.locked", locked4, (b > 0));
      tick();
    end
    last4 = 4'b0001;
    @(negedge clk);
    chk("lk.after", ready4, 4'b0001);
    chk("lk.unlocked", locked4, 1'b0);
    tick();

    // Reset mid-lock
    do_reset();
    valid4 = 4'b0010;
    last4 = 4'b0000;
    @(negedge clk);
    chk("rml.beat1", ready4, 4'b0010);
    tick();
    rst = 1'b1;
    valid4 = 4'b0011;
    @(negedge clk);
    chk("rml.rst_ready", ready4, 4'b0000);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rml.locked", locked4, 1'b0);
    chk("rml.winner", ready4, 4'b0001);
    tick();
`endif

    // NUM_REQ=3 wrap
    do_reset();
    valid4 = '0;
    last4 = '0;
    valid3 = 3'b101;
    last3 = 3'b111;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("wrap3.ready", ready3, 3'b001 << w3_exp[c]);
      chk("wrap3.data", dout3, 32'hB000_0000 + w3_exp[c]);
      tick();
    end

    // Randomized traffic on both instances
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      fifo_full = ($urandom_range(0, 3) == 0);
      valid4 = 4'($urandom);
      last4 = 4'($urandom);
      valid3 = 3'($urandom);
      last3 = 3'($urandom);
      for (int i = 0; i < 4; i++) data4[i*DW +: DW] = $urandom;
      for (int i = 0; i < 3; i++) data3[i*DW +: DW] = $urandom;
      tick();
    end
    @(negedge clk);
    chk_on = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time %0t reached, expected finish before 1000000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
